// File: rtl/bam_seq_ctrl.sv
// bam_seq_ctrl: row-serial broken-array (BAM) 8x8 multiplier controller.
// Optional macro BAM_SEQ_EXACT_EN adds an 'exact' input that forces a full product.
`default_nettype none

module bam_seq_ctrl #(
  parameter int H = 5,
  parameter int V = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
`ifdef BAM_SEQ_EXACT_EN
  input  logic        exact,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] ROW_START = 3'(H);

  state_t      state;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic        exact_r;
  logic [2:0]  row;
  logic [15:0] acc;

  logic        exact_in;
  logic [7:0]  mask;
  logic [7:0]  row_bits;
  logic [15:0] row_term;
  logic [15:0] acc_next;

`ifdef BAM_SEQ_EXACT_EN
  assign exact_in = exact;
`else
  assign exact_in = 1'b0;
`endif

  // Bit i of the current row survives only when its weight i+row reaches the vertical cut.
  always_comb begin
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i] = exact_r || ((i + int'(row)) >= V);
    end
  end

  assign row_bits = b_r[row] ? (a_r & mask) : 8'd0;
  assign row_term = {8'd0, row_bits} << row;
  assign acc_next = acc + row_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      exact_r   <= 1'b0;
      row       <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            exact_r  <= exact_in;
            acc      <= '0;
            row      <= exact_in ? 3'd0 : ROW_START;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          row <= row + 3'd1;
          if (row == 3'd7) begin
            state     <= S_DONE;
            out       <= acc_next;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Result is held until the consumer takes it; no new operands meanwhile.
          if (out_ready) begin
            state     <= S_IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bam_seq_ctrl.sv
// Self-checking bench for bam_seq_ctrl against a term-by-term BAM product model.
`default_nettype none

module tb_bam_seq_ctrl;

  localparam int H = 5;
  localparam int V = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        exact;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bam_seq_ctrl #(.H(H), .V(V)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
`ifdef BAM_SEQ_EXACT_EN
    .exact    (exact),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
  );

  // Product as a plain sum of the kept partial-product terms.
  function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv, input logic ex);
    int sum;
    int hh;
    int vv;
    sum = 0;
    hh  = ex ? 0 : H;
    vv  = ex ? 0 : V;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        if (j >= hh && i + j >= vv && av[i] && bv[j]) sum += (1 << (i + j));
    return 16'(sum);
  endfunction

  function automatic logic eff_exact(input logic ex);
`ifdef BAM_SEQ_EXACT_EN
    return ex;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: offer, accept, run, hold in DONE for 'hold' cycles, release.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ex, input int hold);
    logic [15:0] expv;
    int n;
    int lat;
    expv = model(av, bv, eff_exact(ex));
    n    = eff_exact(ex) ? 8 : 8 - H;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready_before: in_ready=%b want 1", in_ready);
    end
    a = av; b = bv; exact = ex; in_valid = 1'b1;
    step;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out !== 16'd0) begin
        errors++;
        $display("FAIL op_run_flags: in_ready=%b busy=%b out=%h want 0 1 0000", in_ready, busy, out);
      end
      // Garbage operands and stray out_ready during RUN must be ignored.
      a = 8'($urandom); b = 8'($urandom); exact = 1'($urandom);
      out_ready = 1'($urandom);
      step;
      lat++;
    end
    out_ready = 1'b0;
    checks++;
    if (lat !== n) begin
      errors++;
      $display("FAIL op_latency: cycles=%0d want %0d", lat, n);
    end
    checks++;
    if (out !== expv || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL op_result a=%h b=%h ex=%b: out=%h in_ready=%b busy=%b want %h 0 1",
               av, bv, ex, out, in_ready, busy, expv);
    end
    for (int k = 0; k < hold; k++) begin
      step;
      checks++;
      if (out_valid !== 1'b1 || out !== expv || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL op_hold: out_valid=%b out=%h in_ready=%b want 1 %h 0", out_valid, out, in_ready, expv);
      end
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    // in_valid still high across the release edge: must not be accepted there.
    checks++;
    if (out_valid !== 1'b0 || out !== 16'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL op_release: out_valid=%b out=%h in_ready=%b busy=%b want 0 0000 1 0",
               out_valid, out, in_ready, busy);
    end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 8'hFF; b = 8'hFF; exact = 1'b0;
    step;
    step;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h busy=%b want 1 0 0000 0",
               in_ready, out_valid, out, busy);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: busy=%b in_ready=%b want 0 1", busy, in_ready);
    end
  endtask

  task automatic test_vectors;
    do_op(8'hFF, 8'hFF, 1'b0, 0);
    do_op(8'h10, 8'h80, 1'b0, 0);
    do_op(8'h08, 8'h80, 1'b0, 0);
    do_op(8'h00, 8'hFF, 1'b0, 0);
    do_op(8'hFF, 8'h00, 1'b0, 0);
    do_op(8'd13, 8'd11, 1'b0, 1);
    do_op(8'hFF, 8'hFF, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    do_op(8'($urandom), 8'($urandom), 1'b0, 5);
  endtask

  task automatic test_random;
    for (int t = 0; t < 25; t++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 4; t++) do_op(8'($urandom), 8'($urandom), 1'b0, 0);
  endtask

  task automatic check_no_result(input string tag);
    for (int k = 0; k < 10; k++) begin
      step;
      checks++;
      if (out_valid !== 1'b0 || out !== 16'd0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_aborted: out_valid=%b out=%h in_ready=%b want 0 0000 1", tag, out_valid, out, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    a = 8'hFF; b = 8'hFF; exact = 1'b0; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    step;
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out !== 16'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_run: out_valid=%b out=%h in_ready=%b busy=%b want 0 0000 1 0",
               out_valid, out, in_ready, busy);
    end
    check_no_result("rst_run");
    do_op(8'hFF, 8'hFF, 1'b0, 0);
    // Reset while the result is waiting in DONE.
    a = 8'h5A; b = 8'hC3; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_done_reach: out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_done: out_valid=%b out=%h in_ready=%b want 0 0000 1", out_valid, out, in_ready);
    end
    check_no_result("rst_done");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; exact = 1'b0;
    test_reset;
    test_vectors;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
